// File: rtl/core_seq_pkg.sv
// Shared encodings for the core sequencer: FSM states, fault causes and the
// R-type opcode accepted by the decode check.
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_TIMEOUT = 2'b01,
        CAUSE_ILLEGAL = 2'b10
    } cause_t;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    function automatic logic is_rtype(input logic [6:0] opc);
        return opc == OPC_RTYPE;
    endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer for the single-issue core: fetch handshake, decode check,
// execute and writeback, with run/step control, fetch timeout and illegal-opcode trap.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             imem_ready,
    input  logic [31:0]      inst_code,
    input  logic             write_on_register,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write_en,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] retired_count,
    output logic [2:0]       state
);

    // Counter holds the number of missed FETCH cycles so far (0..TIMEOUT-1).
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             cur;
    cause_t             cause;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [CNT_W-1:0]   retired;
    logic               unused_inst;

    assign unused_inst = ^inst_code[31:7];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur     <= ST_IDLE;
            cause   <= CAUSE_NONE;
            tmo_cnt <= '0;
            retired <= '0;
        end else begin
            unique case (cur)
                ST_IDLE: begin
                    if (run || step) begin
                        cur <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        tmo_cnt <= '0;
                        cur     <= ST_DECODE;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        tmo_cnt <= '0;
                        cause   <= CAUSE_TIMEOUT;
                        cur     <= ST_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (is_rtype(inst_code[6:0])) begin
                        cur <= ST_EXECUTE;
                    end else begin
                        cause <= CAUSE_ILLEGAL;
                        cur   <= ST_FAULT;
                    end
                end
                ST_EXECUTE: begin
                    cur <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    retired <= retired + CNT_W'(1);
                    cur     <= run ? ST_FETCH : ST_IDLE;
                end
                ST_FAULT: begin
                    cur <= ST_FAULT;
                end
                default: begin
                    cur <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode from the state register so a reset drops them at once;
    // ir_write and reg_write_en additionally qualify on their handshake inputs.
    assign imem_req      = (cur == ST_FETCH);
    assign ir_write      = (cur == ST_FETCH) && imem_ready;
    assign pc_write      = (cur == ST_WRITEBACK);
    assign reg_write_en  = (cur == ST_WRITEBACK) && write_on_register;
    assign busy          = (cur == ST_FETCH) || (cur == ST_DECODE) ||
                           (cur == ST_EXECUTE) || (cur == ST_WRITEBACK);
    assign halted        = (cur == ST_IDLE) || (cur == ST_FAULT);
    assign fault         = (cur == ST_FAULT);
    assign fault_cause   = cause;
    assign retired_count = retired;
    assign state         = cur;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle controller that sequences the single-issue RISC-V core: instruction fetch handshake, decode check, execute and writeback. Gates the control block's register-write strobe and generates PC/IR write enables, so the datapath commits state only in the WRITEBACK cycle. Sits between the instruction fetch unit, control block and datapath at processor top level. Also provides run/single-step control, a fetch timeout, illegal-opcode trapping and a retired-instruction counter.

Parameters:
TIMEOUT, 16, max consecutive FETCH cycles without imem_ready before fault (>=1)
CNT_W, 32, width of retired_count

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low; low = reset
run  input  1  level; 1 = execute continuously
step  input  1  single-cycle pulse; executes one instruction when run=0 and in IDLE
imem_ready  input  1  instruction memory response valid this cycle
inst_code  input  32  instruction word from fetch unit (opcode [6:0] checked)
write_on_register  input  1  register-write request from control block
imem_req  output  1  fetch request to instruction memory
ir_write  output  1  latch inst_code into instruction register
pc_write  output  1  advance PC (PC+4)
reg_write_en  output  1  gated register-file write enable to datapath
busy  output  1  instruction in flight
halted  output  1  in IDLE or FAULT
fault  output  1  sticky fault flag
fault_cause  output  2  00 none, 01 fetch timeout, 10 illegal opcode
retired_count  output  CNT_W  instructions completed
state  output  3  current state encoding (debug)

Behaviour:
- Reset (reset=0, async): state=IDLE, timeout counter=0, retired_count=0, fault=0, fault_cause=00; all strobes 0; halted=1, busy=0.
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, FAULT=5.
- IDLE: run=1 or step=1 -> FETCH. Else stay.
- FETCH: imem_req=1. imem_ready=1 -> ir_write=1 same cycle (Mealy), counter cleared, -> DECODE. imem_ready=0 -> counter++; if the TIMEOUT-th consecutive FETCH cycle has imem_ready=0 -> FAULT, cause 01. Ready on the TIMEOUT-th cycle is accepted.
- DECODE: inst_code[6:0]==7'b0110011 (R-type) -> EXECUTE; any other opcode -> FAULT, cause 10.
- EXECUTE: one cycle, no strobes, -> WRITEBACK.
- WRITEBACK: reg_write_en = write_on_register; pc_write=1; retired_count++ (wraps 2^CNT_W-1 -> 0). Next: run=1 -> FETCH, else IDLE.
- FAULT: sticky until reset; fault=1, halted=1, no strobes, run/step ignored.
- Outputs other than ir_write and reg_write_en are decoded from the registered state only. reg_write_en, pc_write and ir_write are never asserted outside their stated state.
- busy=1 in FETCH..WRITEBACK; halted=1 in IDLE/FAULT.
- Latency: 4 cycles/instruction with ready on first FETCH cycle; +1 per wait cycle.
- run dropped mid-instruction: current instruction completes, then IDLE. step while busy or while run=1: ignored (not queued). step and run both high in IDLE: behaves as run.
- Reset asserted mid-instruction: abort immediately; no partial writeback strobes after reset assertion.

Decomposition:
- Package core_seq_pkg: state encodings, fault_cause codes, OPC_RTYPE=7'b0110011.
- Single module; no sub-module needed (timeout counter and retire counter are inline registers).

Test Plan:
- Reset low during WRITEBACK -> same-cycle outputs all 0, state=0, retired_count=0, halted=1.
- run=1, imem_ready=1, inst_code=0x002081B3 (add x3,x1,x2), write_on_register=1 -> pc_write and reg_write_en pulse every 4th cycle; retired_count=10 after 40 cycles.
- run=0, one step pulse -> exactly one FETCH..WRITEBACK, return to IDLE, retired_count=1; second step during busy ignored.
- TIMEOUT=16, imem_ready held 0 -> FAULT after 16 FETCH cycles, fault=1, fault_cause=01, pc_write never asserted; ready on 16th cycle instead -> DECODE, no fault.
- inst_code=0x00000013 (addi) -> FAULT from DECODE, fault_cause=10, reg_write_en and pc_write never asserted, run ignored until reset.
- imem_ready delayed 3 cycles, run dropped during EXECUTE -> instruction completes in 7 cycles, one retire, then IDLE.
